// File: rtl/hasti_slave_demux_if.sv
// HASTI slave-side bus bundle.
// One instance carries one point-to-point link between a master-facing
// port and a slave-facing port.
//   modport n : the near (upstream) side as seen by the demux. It receives
//               the address/control/write data, hsel and hready, and it
//               returns hrdata/hreadyout/hresp.
//   modport f : the far (downstream) side as seen by the demux. It drives
//               the address/control/write data, hsel and hready, and it
//               receives hrdata/hreadyout/hresp from the slave.
interface if_hasti_slave_io;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hsel;
    logic        hready;
    logic        hreadyout;
    logic        hresp;

    modport n (
        input  haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        input  hsel, hready,
        output hrdata, hreadyout, hresp
    );

    modport f (
        output haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata,
        output hsel, hready,
        input  hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/hasti_slave_demux.sv
// HASTI single-master to three-slave address decoder and response mux.
// A built-in default slave answers unmapped transfers with the two-cycle
// ERROR response.
//   hclk    : clock, all state on the rising edge
//   hresetn : asynchronous active-low reset
//   in      : upstream bus (from the master side)
//   out0-2  : slave ports for regions 0..2
//
// Default slave states:
//   state   | meaning
//   DS_IDLE | no error pending, OKAY with zero wait
//   DS_ERR1 | first ERROR cycle, hreadyout low
//   DS_ERR2 | second ERROR cycle, hreadyout high
module hasti_slave_demux #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S1_BASE = 32'h8000_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
    parameter logic [31:0] S2_BASE = 32'h4000_0000,
    parameter logic [31:0] S2_MASK = 32'hF000_0000
) (
    input logic          hclk,
    input logic          hresetn,
    if_hasti_slave_io.n  in,
    if_hasti_slave_io.f  out0,
    if_hasti_slave_io.f  out1,
    if_hasti_slave_io.f  out2
);

    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_S0   = 3'd1,
        SEL_S1   = 3'd2,
        SEL_S2   = 3'd3,
        SEL_DEF  = 3'd4
    } sel_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    logic      match_0, match_1, match_2;
    sel_t      sel_addr, sel_data;
    ds_state_t ds_state, ds_next;
    logic      def_hreadyout, def_hresp;
    logic      accept_def;

    // Address decode; fixed priority 0 > 1 > 2 on overlapping regions.
    assign match_0 = ((in.haddr & S0_MASK) == S0_BASE);
    assign match_1 = ((in.haddr & S1_MASK) == S1_BASE);
    assign match_2 = ((in.haddr & S2_MASK) == S2_BASE);

    always_comb begin
        sel_addr = SEL_NONE;
        if (in.hsel) begin
            if (match_0)      sel_addr = SEL_S0;
            else if (match_1) sel_addr = SEL_S1;
            else if (match_2) sel_addr = SEL_S2;
            else              sel_addr = SEL_DEF;
        end
    end

    // Address phase broadcast; every slave sees the muxed global ready.
    assign out0.haddr     = in.haddr;
    assign out0.hwrite    = in.hwrite;
    assign out0.hsize     = in.hsize;
    assign out0.hburst    = in.hburst;
    assign out0.hprot     = in.hprot;
    assign out0.htrans    = in.htrans;
    assign out0.hmastlock = in.hmastlock;
    assign out0.hwdata    = in.hwdata;
    assign out0.hsel      = (sel_addr == SEL_S0);
    assign out0.hready    = in.hreadyout;

    assign out1.haddr     = in.haddr;
    assign out1.hwrite    = in.hwrite;
    assign out1.hsize     = in.hsize;
    assign out1.hburst    = in.hburst;
    assign out1.hprot     = in.hprot;
    assign out1.htrans    = in.htrans;
    assign out1.hmastlock = in.hmastlock;
    assign out1.hwdata    = in.hwdata;
    assign out1.hsel      = (sel_addr == SEL_S1);
    assign out1.hready    = in.hreadyout;

    assign out2.haddr     = in.haddr;
    assign out2.hwrite    = in.hwrite;
    assign out2.hsize     = in.hsize;
    assign out2.hburst    = in.hburst;
    assign out2.hprot     = in.hprot;
    assign out2.htrans    = in.htrans;
    assign out2.hmastlock = in.hmastlock;
    assign out2.hwdata    = in.hwdata;
    assign out2.hsel      = (sel_addr == SEL_S2);
    assign out2.hready    = in.hreadyout;

    // Data-phase owner; only advances when the current data phase completes.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            sel_data <= SEL_NONE;
        end else if (in.hready) begin
            sel_data <= sel_addr;
        end
    end

    // Response mux.
    always_comb begin
        in.hrdata    = 32'd0;
        in.hreadyout = 1'b1;
        in.hresp     = HRESP_OKAY;
        case (sel_data)
            SEL_S0: begin
                in.hrdata    = out0.hrdata;
                in.hreadyout = out0.hreadyout;
                in.hresp     = out0.hresp;
            end
            SEL_S1: begin
                in.hrdata    = out1.hrdata;
                in.hreadyout = out1.hreadyout;
                in.hresp     = out1.hresp;
            end
            SEL_S2: begin
                in.hrdata    = out2.hrdata;
                in.hreadyout = out2.hreadyout;
                in.hresp     = out2.hresp;
            end
            SEL_DEF: begin
                in.hreadyout = def_hreadyout;
                in.hresp     = def_hresp;
            end
            default: begin
                in.hrdata    = 32'd0;
                in.hreadyout = 1'b1;
                in.hresp     = HRESP_OKAY;
            end
        endcase
    end

    // Default slave. IDLE/BUSY to an unmapped address is not accepted and
    // gets a zero-wait OKAY.
    assign accept_def = in.hready && (sel_addr == SEL_DEF) &&
                        ((in.htrans == HTRANS_NONSEQ) || (in.htrans == HTRANS_SEQ));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ds_state <= DS_IDLE;
        end else begin
            ds_state <= ds_next;
        end
    end

    always_comb begin
        ds_next       = ds_state;
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_OKAY;
        case (ds_state)
            DS_IDLE: begin
                if (accept_def) ds_next = DS_ERR1;
            end
            DS_ERR1: begin
                def_hreadyout = 1'b0;
                def_hresp     = HRESP_ERROR;
                ds_next       = DS_ERR2;
            end
            DS_ERR2: begin
                def_hresp = HRESP_ERROR;
                // Back-to-back unmapped transfer restarts the error sequence.
                ds_next   = accept_def ? DS_ERR1 : DS_IDLE;
            end
            default: begin
                ds_next = DS_IDLE;
            end
        endcase
    end

`ifndef SYNTHESIS
    if ((S0_BASE & ~S0_MASK) != 32'd0) begin : g_s0_base_chk
        $error("hasti_slave_demux: S0_BASE has bits outside S0_MASK");
    end
    if ((S1_BASE & ~S1_MASK) != 32'd0) begin : g_s1_base_chk
        $error("hasti_slave_demux: S1_BASE has bits outside S1_MASK");
    end
    if ((S2_BASE & ~S2_MASK) != 32'd0) begin : g_s2_base_chk
        $error("hasti_slave_demux: S2_BASE has bits outside S2_MASK");
    end

    // Remembers whether the previous cycle was the first half of an ERROR.
    logic err_wait_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_wait_q <= 1'b0;
        end else begin
            err_wait_q <= (in.hresp == HRESP_ERROR) && !in.hreadyout;
        end
    end

    always @(posedge hclk) begin
        if (hresetn && in.hsel && ($countones({match_2, match_1, match_0}) > 1))
            $info("hasti_slave_demux: overlapping regions at %h", in.haddr);
        if (hresetn && (in.hresp == HRESP_ERROR) && in.hreadyout && !err_wait_q)
            $error("hasti_slave_demux: single-cycle ERROR response");
    end
`endif

endmodule

// File: tb/tb_hasti_slave_demux.sv
module tb_hasti_slave_demux;

    logic hclk = 1'b0;
    logic hresetn = 1'b1;

    always #5 hclk = ~hclk;

    if_hasti_slave_io bus_in ();
    if_hasti_slave_io bus_s0 ();
    if_hasti_slave_io bus_s1 ();
    if_hasti_slave_io bus_s2 ();

    hasti_slave_demux dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .in      (bus_in),
        .out0    (bus_s0),
        .out1    (bus_s1),
        .out2    (bus_s2)
    );

    // The interconnect feeds the muxed ready straight back as hready.
    assign bus_in.hready = bus_in.hreadyout;

    typedef struct {
        string       name;
        logic        rdy;
        logic        resp;
        logic [31:0] rdata;
        logic [2:0]  selv;
        logic        ordy;
        logic        wchk;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, act, expv);
        end
    endtask

    // Monitor: pops one expectation per cycle, sampled mid-cycle.
    always @(negedge hclk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check({mon_e.name, ".hreadyout"}, {31'd0, bus_in.hreadyout}, {31'd0, mon_e.rdy});
            check({mon_e.name, ".hresp"},     {31'd0, bus_in.hresp},     {31'd0, mon_e.resp});
            check({mon_e.name, ".hrdata"},    bus_in.hrdata,             mon_e.rdata);
            check({mon_e.name, ".hsel"},      {29'd0, bus_s2.hsel, bus_s1.hsel, bus_s0.hsel},
                  {29'd0, mon_e.selv});
            check({mon_e.name, ".out_hready"}, {31'd0, bus_s2.hready},   {31'd0, mon_e.ordy});
            if (mon_e.wchk)
                check({mon_e.name, ".out1_hwdata"}, bus_s1.hwdata, mon_e.wdata);
        end
    end

    task automatic set_m(input logic [31:0] addr, input logic [1:0] trans,
                         input logic write, input logic sel, input logic [31:0] wdata);
        bus_in.haddr  = addr;
        bus_in.htrans = trans;
        bus_in.hwrite = write;
        bus_in.hsel   = sel;
        bus_in.hwdata = wdata;
    endtask

    task automatic step(input string name, input logic rdy, input logic resp,
                        input logic [31:0] rdata, input logic [2:0] selv, input logic ordy,
                        input logic wchk = 1'b0, input logic [31:0] wdata = 32'd0);
        exp_t e;
        e.name = name; e.rdy = rdy; e.resp = resp; e.rdata = rdata;
        e.selv = selv; e.ordy = ordy; e.wchk = wchk; e.wdata = wdata;
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
    endtask

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] NSEQ = 2'b10;

    initial begin
        #1 hresetn = 1'b0;
        bus_in.hsize = 3'd2; bus_in.hburst = 3'd0; bus_in.hprot = 4'h3; bus_in.hmastlock = 1'b0;
        set_m(32'h0, IDLE, 1'b0, 1'b0, 32'h0);
        bus_s0.hrdata = 32'hDEAD_BEEF; bus_s0.hreadyout = 1'b1; bus_s0.hresp = 1'b0;
        bus_s1.hrdata = 32'h0000_1111; bus_s1.hreadyout = 1'b1; bus_s1.hresp = 1'b0;
        bus_s2.hrdata = 32'hCAFE_F00D; bus_s2.hreadyout = 1'b1; bus_s2.hresp = 1'b0;
        @(posedge hclk); #1;

        step("rst_idle", 1, 0, 32'h0, 3'b000, 1);
        hresetn = 1'b1;
        step("post_rst", 1, 0, 32'h0, 3'b000, 1);

        // Zero-wait read from slave 0.
        set_m(32'h0000_0010, NSEQ, 0, 1, 32'h0);
        step("rd0_addr", 1, 0, 32'h0, 3'b001, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("rd0_data", 1, 0, 32'hDEAD_BEEF, 3'b000, 1);

        // Write to slave 1 with two waits, pipelined read to slave 2.
        set_m(32'h8000_0004, NSEQ, 1, 1, 32'h0);
        step("wr1_addr", 1, 0, 32'h0, 3'b010, 1);
        set_m(32'h4000_0000, NSEQ, 0, 1, 32'h1234_5678);
        bus_s1.hreadyout = 1'b0;
        step("wr1_wait1", 0, 0, 32'h0000_1111, 3'b100, 0, 1, 32'h1234_5678);
        step("wr1_wait2", 0, 0, 32'h0000_1111, 3'b100, 0, 1, 32'h1234_5678);
        bus_s1.hreadyout = 1'b1;
        step("wr1_done", 1, 0, 32'h0000_1111, 3'b100, 1, 1, 32'h1234_5678);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("rd2_data", 1, 0, 32'hCAFE_F00D, 3'b000, 1);

        // Single unmapped transfer.
        set_m(32'h2000_0000, NSEQ, 0, 1, 32'h0);
        step("um_addr", 1, 0, 32'h0, 3'b000, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("um_err1", 0, 1, 32'h0, 3'b000, 0);
        step("um_err2", 1, 1, 32'h0, 3'b000, 1);
        step("um_okay", 1, 0, 32'h0, 3'b000, 1);

        // Back-to-back unmapped transfers.
        set_m(32'h2000_0000, NSEQ, 0, 1, 32'h0);
        step("bb_addr", 1, 0, 32'h0, 3'b000, 1);
        set_m(32'h2000_0004, NSEQ, 0, 1, 32'h0);
        step("bb_err1a", 0, 1, 32'h0, 3'b000, 0);
        step("bb_err2a", 1, 1, 32'h0, 3'b000, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("bb_err1b", 0, 1, 32'h0, 3'b000, 0);
        step("bb_err2b", 1, 1, 32'h0, 3'b000, 1);
        step("bb_okay", 1, 0, 32'h0, 3'b000, 1);

        // IDLE to an unmapped address: zero-wait OKAY.
        set_m(32'h2000_0000, IDLE, 0, 1, 32'h0);
        step("ui_addr", 1, 0, 32'h0, 3'b000, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("ui_data", 1, 0, 32'h0, 3'b000, 1);

        // Region edges.
        set_m(32'h0000_FFFC, NSEQ, 0, 1, 32'h0);
        step("edge_s0_top", 1, 0, 32'h0, 3'b001, 1);
        set_m(32'h4FFF_FFFC, NSEQ, 0, 1, 32'h0);
        step("edge_s2_top", 1, 0, 32'hDEAD_BEEF, 3'b100, 1);
        set_m(32'h0001_0000, NSEQ, 0, 1, 32'h0);
        step("edge_s0_past", 1, 0, 32'hCAFE_F00D, 3'b000, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("edge_err1", 0, 1, 32'h0, 3'b000, 0);
        step("edge_err2", 1, 1, 32'h0, 3'b000, 1);
        step("edge_okay", 1, 0, 32'h0, 3'b000, 1);

        // Reset during a slave 1 wait state.
        set_m(32'h8000_0000, NSEQ, 1, 1, 32'h0);
        step("rw_addr", 1, 0, 32'h0, 3'b010, 1);
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        bus_s1.hreadyout = 1'b0;
        step("rw_wait", 0, 0, 32'h0000_1111, 3'b000, 0);
        hresetn = 1'b0;
        set_m(32'h8000_0000, NSEQ, 0, 1, 32'h0);
        step("rw_in_rst", 1, 0, 32'h0, 3'b010, 1);
        hresetn = 1'b1;
        bus_s1.hreadyout = 1'b1;
        set_m(32'h0, IDLE, 0, 0, 32'h0);
        step("rw_release", 1, 0, 32'h0, 3'b000, 1);
        step("rw_idle", 1, 0, 32'h0, 3'b000, 1);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(posedge hclk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "timeout");
    end

endmodule
